// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one block-encryptor core between two requesters.
// Latency: ack 1 cycle after grant, core strobe 1 cycle after ack, result passes through combinationally.
// Backpressure: requests wait until IDLE with core_ready high; the core result is held until the owner takes it.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   reqN_data/reqN_stb/reqN_ack   plaintext request handshake, N = 0, 1
//   resN_data/resN_valid/resN_stb ciphertext result handshake, N = 0, 1
//   core_datain/core_dat_stb      block issue to the core
//   core_ready/core_o_valid/core_dataout/core_o_stb  core status, result and release
//   busy, owner                   FSM not idle; index of the current grant
//
// Build option: define AES_ARB_ROUND_ROBIN_EN to alternate grants on a tie;
// without it requester 0 always wins a tie.

module aes_core_arbiter #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_stb,
  output logic              req0_ack,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_stb,
  output logic              req1_ack,

  output logic [DATA_W-1:0] res0_data,
  output logic              res0_valid,
  input  logic              res0_stb,
  output logic [DATA_W-1:0] res1_data,
  output logic              res1_valid,
  input  logic              res1_stb,

  output logic [DATA_W-1:0] core_datain,
  output logic              core_dat_stb,
  input  logic              core_ready,
  input  logic              core_o_valid,
  input  logic [DATA_W-1:0] core_dataout,
  output logic              core_o_stb,

  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic [DATA_W-1:0] data_reg_q;
  logic              req0_ack_q;
  logic              req1_ack_q;
  logic              dat_stb_q;

  logic any_req;
  logic winner;
  logic in_wait;
  logic res_take;

  assign any_req = req0_stb | req1_stb;

`ifdef AES_ARB_ROUND_ROBIN_EN
  // On a tie the requester that was not served last wins; a lone request
  // wins outright (req1_stb alone selects 1, req0_stb alone selects 0).
  assign winner = (req0_stb && req1_stb) ? ~last_owner_q : req1_stb;
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  assign winner = ~req0_stb;

  // last_owner is still tracked so both builds hold identical state.
  logic last_owner_unused;
  assign last_owner_unused = last_owner_q;
`endif

  assign in_wait  = (state_q == WAIT);
  // Only the owner's consume strobe counts, and only while the core offers data.
  assign res_take = core_o_valid & (owner_q ? res1_stb : res0_stb);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      data_reg_q   <= '0;
      req0_ack_q   <= 1'b0;
      req1_ack_q   <= 1'b0;
      dat_stb_q    <= 1'b0;
    end else begin
      // Acks and the core strobe are single-cycle pulses.
      req0_ack_q <= 1'b0;
      req1_ack_q <= 1'b0;
      dat_stb_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core_ready && any_req) begin
            data_reg_q <= winner ? req1_data : req0_data;
            owner_q    <= winner;
            req0_ack_q <= ~winner;
            req1_ack_q <= winner;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // The strobe is the registered output of ISSUE, so the core sees
          // it the cycle after the ack, while data_reg is already stable.
          dat_stb_q <= 1'b1;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (res_take) begin
            last_owner_q <= owner_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ack     = req0_ack_q;
  assign req1_ack     = req1_ack_q;
  assign core_datain  = data_reg_q;
  assign core_dat_stb = dat_stb_q;

  // The core's result is steered to the owner; both data buses carry it.
  assign res0_data    = core_dataout;
  assign res1_data    = core_dataout;
  assign res0_valid   = in_wait & ~owner_q & core_o_valid;
  assign res1_valid   = in_wait &  owner_q & core_o_valid;
  assign core_o_stb   = in_wait & res_take;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
module tb_aes_core_arbiter;

  localparam int DW = 128;
  localparam int CORE_LAT = 2;
  localparam logic [127:0] KEY   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] D28   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D30   = 128'hCAFEF00DDEADBEEF0123456789ABCDEF;
  localparam logic [127:0] D32   = 128'h55AA55AA55AA55AA55AA55AA55AA55AA;
  localparam logic [127:0] BASE0 = 128'hA0000000000000000000000000000000;
  localparam logic [127:0] BASE1 = 128'hB0000000000000000000000000000000;

  logic          clk;
  logic          reset;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_stb, req1_stb;
  logic          req0_ack, req1_ack;
  logic [DW-1:0] res0_data, res1_data;
  logic          res0_valid, res1_valid;
  logic          res0_stb, res1_stb;
  logic [DW-1:0] core_datain;
  logic          core_dat_stb;
  logic          core_ready;
  logic          core_o_valid;
  logic [DW-1:0] core_dataout;
  logic          core_o_stb;
  logic          busy, owner;

  // Requests come either from the directed sequence or from the auto requesters.
  logic          m_stb0, m_stb1, auto0, auto1;
  logic [DW-1:0] m_data0, m_data1, a_data0, a_data1;

  assign req0_stb  = auto0 | m_stb0;
  assign req1_stb  = auto1 | m_stb1;
  assign req0_data = auto0 ? a_data0 : m_data0;
  assign req1_data = auto1 ? a_data1 : m_data1;

  aes_core_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_stb(req0_stb), .req0_ack(req0_ack),
    .req1_data(req1_data), .req1_stb(req1_stb), .req1_ack(req1_ack),
    .res0_data(res0_data), .res0_valid(res0_valid), .res0_stb(res0_stb),
    .res1_data(res1_data), .res1_valid(res1_valid), .res1_stb(res1_stb),
    .core_datain(core_datain), .core_dat_stb(core_dat_stb), .core_ready(core_ready),
    .core_o_valid(core_o_valid), .core_dataout(core_dataout), .core_o_stb(core_o_stb),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic         id;
    logic [127:0] dat;
  } exp_t;

  exp_t sb[$];
  logic ack_order[$];
  int   acks0 = 0;
  int   acks1 = 0;
  int   results = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / grant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ack) begin acks0++; ack_order.push_back(1'b0); end
      if (req1_ack) begin acks1++; ack_order.push_back(1'b1); end
      if (core_o_stb) begin
        results++;
        check("sb_nonempty", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("res_owner_valid", 128'(res1_valid), 128'(e.id));
          check("res_other_valid", 128'(e.id ? res0_valid : res1_valid), 128'd0);
          check("res_data", e.id ? res1_data : res0_data, e.dat);
        end
      end
    end
  end

  // Behavioural encryptor: result = block ^ KEY, CORE_LAT cycles after the strobe.
  initial begin
    logic issued, taken;
    logic [127:0] din, cres;
    int cnt;
    core_o_valid = 1'b0;
    core_dataout = '0;
    cnt  = 0;
    cres = '0;
    forever begin
      @(negedge clk);
      issued = core_dat_stb;
      taken  = core_o_stb;
      din    = core_datain;
      @(posedge clk); #1;
      if (reset) begin
        core_o_valid = 1'b0;
        cnt = 0;
      end else begin
        if (taken) core_o_valid = 1'b0;
        if (issued) begin
          cnt  = CORE_LAT;
          cres = din ^ KEY;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_o_valid = 1'b1;
            core_dataout = cres;
          end
        end
      end
    end
  end

  // Auto requesters: new block value after every ack while enabled.
  initial begin
    int k0, k1;
    k0 = 0; k1 = 0;
    a_data0 = BASE0;
    a_data1 = BASE1;
    forever begin
      logic g0, g1;
      @(negedge clk);
      g0 = req0_ack & auto0;
      g1 = req1_ack & auto1;
      @(posedge clk); #1;
      if (g0) begin k0++; a_data0 = BASE0 + 128'(k0); end
      if (g1) begin k1++; a_data1 = BASE1 + 128'(k1); end
    end
  end

  initial begin
    int n, base_res, a0b, a1b;
    logic exp_order[4];
    reset = 1'b1;
    m_stb0 = 0; m_stb1 = 0; m_data0 = '0; m_data1 = '0;
    auto0 = 0; auto1 = 0;
    res0_stb = 0; res1_stb = 0;
    core_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy), 0);
    check("rst_owner", 128'(owner), 0);
    check("rst_acks", 128'({req0_ack, req1_ack}), 0);
    check("rst_dat_stb", 128'(core_dat_stb), 0);
    check("rst_datain", core_datain, 0);
    check("rst_valids", 128'({res0_valid, res1_valid, core_o_stb}), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single request from 0, then non-owner / owner consume
    @(posedge clk); #1;
    m_stb0 = 1; m_data0 = D28;
    sb.push_back('{1'b0, D28 ^ KEY});
    @(negedge clk);
    check("t28_ack_early", 128'(req0_ack), 0);
    check("t28_idle", 128'(busy), 0);
    @(negedge clk);
    check("t28_ack0", 128'(req0_ack), 1);
    check("t28_ack1", 128'(req1_ack), 0);
    check("t28_busy", 128'(busy), 1);
    check("t28_owner", 128'(owner), 0);
    check("t28_stb_early", 128'(core_dat_stb), 0);
    @(posedge clk); #1 m_stb0 = 0;
    @(negedge clk);
    check("t28_ack_pulse", 128'(req0_ack), 0);
    check("t28_dat_stb", 128'(core_dat_stb), 1);
    check("t28_datain", core_datain, D28);
    @(negedge clk);
    check("t28_dat_stb_once", 128'(core_dat_stb), 0);
    repeat (5) begin
      @(negedge clk);
      check("t28_res0_mirror", 128'(res0_valid), 128'(core_o_valid));
      check("t28_res1_zero", 128'(res1_valid), 0);
    end
    check("t28_res0_valid", 128'(res0_valid), 1);
    check("t28_no_release", 128'(core_o_stb), 0);

    @(posedge clk); #1 res1_stb = 1;
    @(negedge clk);
    check("t31_nonowner_stb", 128'(core_o_stb), 0);
    @(negedge clk);
    check("t31_still_busy", 128'(busy), 1);
    check("t31_still_valid", 128'(res0_valid), 1);
    @(posedge clk); #1 res1_stb = 0; res0_stb = 1;
    @(negedge clk);
    check("t31_owner_stb", 128'(core_o_stb), 1);
    check("t31_res_data", res0_data, D28 ^ KEY);
    @(posedge clk); #1 res0_stb = 0;
    @(negedge clk);
    check("t31_idle_next", 128'(busy), 0);

    // core_ready low holds off a pending request
    @(posedge clk); #1;
    core_ready = 0; m_stb1 = 1; m_data1 = D30;
    repeat (10) begin
      @(negedge clk);
      check("t30_no_ack", 128'(req1_ack), 0);
      check("t30_not_busy", 128'(busy), 0);
    end
    @(posedge clk); #1;
    core_ready = 1;
    sb.push_back('{1'b1, D30 ^ KEY});
    @(negedge clk);
    check("t30_ack_same_cycle", 128'(req1_ack), 0);
    @(negedge clk);
    check("t30_ack1", 128'(req1_ack), 1);
    check("t30_owner", 128'(owner), 1);
    @(posedge clk); #1 m_stb1 = 0; res1_stb = 1;
    n = 0;
    while (busy && n < 30) begin @(negedge clk); n++; end
    check("t30_done", 128'(busy), 0);
    @(posedge clk); #1 res1_stb = 0;

    // Reset in WAIT aborts the transaction
    base_res = results;
    @(posedge clk); #1 m_stb0 = 1; m_data0 = D32;
    @(posedge clk); #1;
    @(posedge clk); #1 m_stb0 = 0;
    repeat (6) @(negedge clk);
    check("t32_pre_valid", 128'(res0_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("t32_busy", 128'(busy), 0);
    check("t32_owner", 128'(owner), 0);
    check("t32_outs", 128'({res0_valid, res1_valid, core_o_stb, core_dat_stb, req0_ack, req1_ack}), 0);
    check("t32_datain", core_datain, 0);
    check("t32_not_delivered", 128'(results), 128'(base_res));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Continuous tie between both requesters for four transactions
`ifdef AES_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    sb.push_back('{1'b0, BASE0 ^ KEY});
    sb.push_back('{1'b1, BASE1 ^ KEY});
    sb.push_back('{1'b0, (BASE0 + 128'd1) ^ KEY});
    sb.push_back('{1'b1, (BASE1 + 128'd1) ^ KEY});
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, (BASE0 + 128'(k)) ^ KEY});
`endif
    ack_order.delete();
    a0b = acks0; a1b = acks1;
    base_res = results;
    @(posedge clk); #1;
    res0_stb = 1; res1_stb = 1;
    auto0 = 1; auto1 = 1;
    n = 0;
    while (results < base_res + 4 && n < 300) begin
      @(negedge clk); #1; n++;
    end
    check("tie_results", 128'(results - base_res), 4);
    @(posedge clk); #1 auto0 = 0; auto1 = 0;
    repeat (6) @(negedge clk);
    check("tie_ack_count", 128'(ack_order.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_order.size()) check("tie_grant_order", 128'(ack_order[i]), 128'(exp_order[i]));
    end
`ifdef AES_ARB_ROUND_ROBIN_EN
    check("tie_acks1", 128'(acks1 - a1b), 2);
    check("tie_acks0", 128'(acks0 - a0b), 2);
`else
    check("tie_acks1_never", 128'(acks1 - a1b), 0);
    check("tie_acks0", 128'(acks0 - a0b), 4);
`endif
    check("sb_drained", 128'(sb.size()), 0);
    check("end_idle", 128'(busy), 0);
    res0_stb = 0; res1_stb = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
